// File: rtl/wb_slave_pipelined_ram.sv
// Wishbone B4 pipelined slave with word-addressed RAM, byte selects, fixed
// completion latency, periodic stall insertion and out-of-range error replies.
module wb_slave_pipelined_ram #(
  parameter int unsigned adr_width   = 16,
  parameter int unsigned dat_width   = 16,
  parameter int unsigned depth       = 1024,
  parameter int unsigned latency     = 1,
  parameter int unsigned stall_every = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cyc_i,
  input  logic                   stb_i,
  input  logic                   we_i,
  input  logic [adr_width-1:0]   adr_i,
  input  logic [dat_width-1:0]   dat_i,
  input  logic [dat_width/8-1:0] sel_i,
  output logic [dat_width-1:0]   dat_o,
  output logic                   ack_o,
  output logic                   err_o,
  output logic                   stall_o
);

  localparam int unsigned SEL_W = dat_width / 8;
  localparam int unsigned IDX_W = (depth > 1) ? $clog2(depth) : 1;
  localparam int unsigned CNT_W = (stall_every > 1) ? $clog2(stall_every) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((stall_every > 0) ? stall_every - 1 : 0);
  localparam logic [adr_width:0] DEPTH_LIM = (adr_width + 1)'(depth);

  logic [dat_width-1:0] mem [depth];
  logic [dat_width-1:0] dat_q [latency];
  logic [latency-1:0]   vld;
  logic [latency-1:0]   err_q;
  logic [CNT_W-1:0]     cnt;
  logic                 accept;
  logic                 in_range;
  logic [IDX_W-1:0]     idx;

  always_comb begin
    accept   = cyc_i & stb_i & ~stall_o;
    in_range = {1'b0, adr_i} < DEPTH_LIM;
    idx      = adr_i[IDX_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (accept && we_i && in_range) begin
      for (int unsigned b = 0; b < SEL_W; b++) begin
        if (sel_i[b]) mem[idx][8*b +: 8] <= dat_i[8*b +: 8];
      end
    end
  end

  // Payload stages carry no reset: they are only observed through vld.
  always_ff @(posedge clk) begin
    dat_q[0] <= (accept && !we_i && in_range) ? mem[idx] : '0;
    err_q[0] <= ~in_range;
    for (int unsigned i = 1; i < latency; i++) begin
      dat_q[i] <= dat_q[i-1];
      err_q[i] <= err_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld     <= '0;
      cnt     <= '0;
      stall_o <= 1'b0;
    end else begin
      if (!cyc_i) begin
        vld <= '0;
      end else begin
        vld[0] <= accept;
        for (int unsigned i = 1; i < latency; i++) vld[i] <= vld[i-1];
      end
      // A stall lasts exactly one cycle; accept is blocked while it is high.
      stall_o <= 1'b0;
      if (stall_every != 0 && accept) begin
        if (cnt == CNT_LAST) begin
          cnt     <= '0;
          stall_o <= 1'b1;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  always_comb begin
    ack_o = vld[latency-1] & ~err_q[latency-1];
    err_o = vld[latency-1] & err_q[latency-1];
    dat_o = ack_o ? dat_q[latency-1] : '0;
  end

endmodule

// File: tb/tb_wb_slave_pipelined_ram.sv
// Scoreboard bench for wb_slave_pipelined_ram: four instances with different
// latency/stall/depth settings, directed requests, monitor checks completions.
module tb_wb_slave_pipelined_ram;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cyc [N];
  logic        stb [N];
  logic        we [N];
  logic [15:0] adr [N];
  logic [15:0] wdat [N];
  logic [1:0]  sel [N];
  logic [15:0] rdat [N];
  logic        ack [N];
  logic        err [N];
  logic        stall [N];

  typedef struct {
    int          inst;
    logic        err;
    logic        chk;
    logic [15:0] dat;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc_cnt = 0;
  int   last_acc = 0;
  int   ncomp [N];

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  for (genvar g = 0; g < N; g++) begin : g_dut
    wb_slave_pipelined_ram #(
      .adr_width  (16),
      .dat_width  (16),
      .depth      ((g == 2) ? 16 : 1024),
      .latency    ((g == 0) ? 1 : (g == 1) ? 3 : (g == 2) ? 4 : 2),
      .stall_every((g == 2) ? 4 : 0)
    ) u_dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .cyc_i  (cyc[g]),
      .stb_i  (stb[g]),
      .we_i   (we[g]),
      .adr_i  (adr[g]),
      .dat_i  (wdat[g]),
      .sel_i  (sel[g]),
      .dat_o  (rdat[g]),
      .ack_o  (ack[g]),
      .err_o  (err[g]),
      .stall_o(stall[g])
    );
  end

  function automatic int lat_of(input int i);
    case (i)
      0:       return 1;
      1:       return 3;
      2:       return 4;
      default: return 2;
    endcase
  endfunction

  function automatic int depth_of(input int i);
    return (i == 2) ? 16 : 1024;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Present one request and hold it until accepted; called just after a negedge.
  task automatic req(input int i, input logic w, input logic [15:0] a,
                     input logic [15:0] d, input logic [1:0] s, input logic push,
                     input logic [15:0] exp_dat);
    int   n;
    logic ok;
    logic st;
    exp_t e;
    cyc[i] = 1'b1; stb[i] = 1'b1; we[i] = w; adr[i] = a; wdat[i] = d; sel[i] = s;
    n = 0; ok = 1'b0;
    while (!ok && n < 20) begin
      st = stall[i];
      @(posedge clk);
      #1;
      if (!st) ok = 1'b1;
      n++;
    end
    if (!ok) begin
      tests++; fails++;
      $display("FAIL accept_timeout inst%0d adr=%0d: not accepted in 20 cycles, required acceptance", i, a);
    end else begin
      last_acc = cyc_cnt;
      if (push) begin
        e.inst = i;
        e.err  = ({16'd0, a} >= depth_of(i));
        e.chk  = !w;
        e.dat  = e.err ? 16'h0000 : exp_dat;
        e.due  = cyc_cnt + lat_of(i) - 1;
        sb.push_back(e);
      end
    end
    @(negedge clk);
    stb[i] = 1'b0;
  endtask

  task automatic wr(input int i, input logic [15:0] a, input logic [15:0] d,
                    input logic [1:0] s);
    req(i, 1'b1, a, d, s, 1'b1, 16'h0000);
  endtask

  task automatic rd(input int i, input logic [15:0] a, input logic [15:0] d);
    req(i, 1'b0, a, 16'h0000, 2'b11, 1'b1, d);
  endtask

  task automatic idle(input int i, input int n);
    stb[i] = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic drop(input int i);
    cyc[i] = 1'b0; stb[i] = 1'b0;
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (ack[i] && err[i]) begin
        tests++; fails++;
        $display("FAIL exclusive inst%0d: ack=1 err=1, required at most one", i);
      end
      if (!ack[i] && rdat[i] != 16'h0000) begin
        tests++; fails++;
        $display("FAIL idle_dat inst%0d: dat_o=%h with ack=0, required 0000", i, rdat[i]);
      end
      if (ack[i] || err[i]) begin
        int   idx;
        exp_t e;
        ncomp[i]++;
        tests++;
        idx = -1;
        for (int k = 0; k < sb.size(); k++) begin
          if (sb[k].inst == i) begin
            idx = k;
            break;
          end
        end
        if (idx < 0) begin
          fails++;
          $display("FAIL unexpected inst%0d cycle %0d: ack=%0b err=%0b, required no completion", i, cyc_cnt, ack[i], err[i]);
        end else begin
          e = sb[idx];
          sb.delete(idx);
          if (err[i] != e.err || (e.chk && rdat[i] != e.dat) || cyc_cnt != e.due) begin
            fails++;
            $display("FAIL completion inst%0d: err=%0b dat=%h cycle=%0d, required err=%0b dat=%h cycle=%0d",
                     i, err[i], rdat[i], cyc_cnt, e.err, e.dat, e.due);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: bench did not finish, required completion");
    $fatal(1);
  end

  initial begin
    int first;
    int base;
    for (int i = 0; i < N; i++) begin
      cyc[i] = 1'b0; stb[i] = 1'b0; we[i] = 1'b0;
      adr[i] = '0; wdat[i] = '0; sel[i] = '0; ncomp[i] = 0;
    end
    #1;
    for (int i = 0; i < N; i++) begin
      chk($sformatf("rst_ack%0d", i), int'(ack[i]), 0);
      chk($sformatf("rst_err%0d", i), int'(err[i]), 0);
      chk($sformatf("rst_stall%0d", i), int'(stall[i]), 0);
      chk($sformatf("rst_dat%0d", i), int'(rdat[i]), 0);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Single transfers with cyc dropped between them, latency 1
    for (int a = 1; a <= 10; a++) begin
      wr(0, 16'(a), 16'(100 + a), 2'b11);
      drop(0);
    end
    for (int a = 1; a <= 10; a++) begin
      rd(0, 16'(a), 16'(100 + a));
      drop(0);
    end
    // Byte enables
    wr(0, 16'd5, 16'hFFFF, 2'b11);
    wr(0, 16'd5, 16'h1234, 2'b01);
    rd(0, 16'd5, 16'hFF34);
    drop(0);

    // Back-to-back burst, latency 3, plus read-after-write
    for (int a = 11; a <= 20; a++) wr(1, 16'(a), 16'(200 + a), 2'b11);
    for (int a = 11; a <= 20; a++) rd(1, 16'(a), 16'(200 + a));
    wr(1, 16'd30, 16'h5555, 2'b11);
    rd(1, 16'd30, 16'h5555);
    idle(1, 5);
    drop(1);

    // Stall insertion every 4 accepts, latency 4, depth 16
    for (int a = 0; a < 12; a++) wr(2, 16'(a), 16'(16'h0300 + a), 2'b11);
    first = 0;
    for (int n = 1; n <= 12; n++) begin
      rd(2, 16'(n - 1), 16'(16'h0300 + n - 1));
      if (n == 1) first = last_acc;
      chk($sformatf("stall_after_%0d", n), int'(stall[2]), (n % 4 == 0) ? 1 : 0);
    end
    chk("stall_span", last_acc - first, 13);
    idle(2, 6);

    // Out-of-range error and upper boundary
    rd(2, 16'd16, 16'h0000);
    wr(2, 16'd17, 16'hDEAD, 2'b11);
    wr(2, 16'd15, 16'h0F0F, 2'b11);
    rd(2, 16'd15, 16'h0F0F);
    idle(2, 6);
    drop(2);

    // Abort: three reads then cyc dropped before any completes
    base = ncomp[2];
    for (int n = 0; n < 3; n++) req(2, 1'b0, 16'(n), 16'h0000, 2'b11, 1'b0, 16'h0000);
    cyc[2] = 1'b0;
    repeat (8) @(negedge clk);
    chk("abort_no_completion", ncomp[2] - base, 0);

    // Reset with two reads in flight, latency 2
    wr(3, 16'd50, 16'hABCD, 2'b11);
    idle(3, 3);
    drop(3);
    req(3, 1'b0, 16'd50, 16'h0000, 2'b11, 1'b0, 16'h0000);
    cyc[3] = 1'b1; stb[3] = 1'b1; we[3] = 1'b0; adr[3] = 16'd51;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ack", int'(ack[3]), 0);
    chk("mid_rst_err", int'(err[3]), 0);
    chk("mid_rst_stall", int'(stall[3]), 0);
    chk("mid_rst_dat", int'(rdat[3]), 0);
    cyc[3] = 1'b0; stb[3] = 1'b0;
    base = ncomp[3];
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("post_rst_no_completion", ncomp[3] - base, 0);
    rd(3, 16'd50, 16'hABCD);
    idle(3, 4);
    drop(3);

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
